int_widen_acc: RTL and testbench

Burst accumulator for narrow integer samples. Each sample is one of byte, byte unsigned, shortint or shortint unsigned. The block widens every sample to 32 bits, sign-extending signed kinds and zero-extending unsigned kinds, then sums BURST samples and emits the total through a valid/ready handshake. It sits directly downstream of the port-typed integer producers and consumes their 8/16-bit outputs.

---
 rtl/int_widen_pkg.sv | 19 +
 rtl/int_widen.sv | 22 ++
 rtl/int_widen_acc.sv | 105 ++++++++++
 tb/tb_int_widen_acc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/int_widen_pkg.sv
// Shared types and constants for the narrow-integer burst accumulator.
package int_widen_pkg;

  localparam int unsigned ACC_W = 32;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IK_BYTE,
    IK_BYTE_U,
    IK_SHORT,
    IK_SHORT_U
  } int_kind_e;

  typedef enum logic {
    ST_ACC,
    ST_EMIT
  } state_e;

endpackage

// File: rtl/int_widen.sv
// Combinational widening of an 8/16-bit sample to 32 bits by kind.
module int_widen
  import int_widen_pkg::*;
(
  input  int_kind_e          kind,
  input  logic [15:0]        d,
  output logic [ACC_W-1:0]   ext
);

  // Sign- or zero-extend according to kind; byte kinds ignore d[15:8].
  always_comb begin
    ext = '0;
    unique case (kind)
      IK_BYTE:    ext = {{24{d[7]}}, d[7:0]};
      IK_BYTE_U:  ext = {24'b0, d[7:0]};
      IK_SHORT:   ext = {{16{d[15]}}, d};
      IK_SHORT_U: ext = {16'b0, d};
      default:    ext = '0;
    endcase
  end

endmodule

// File: rtl/int_widen_acc.sv
// Burst accumulator: widens narrow samples, sums BURST of them (or fewer on
// flush) and presents the total on a valid/ready output.
module int_widen_acc
  import int_widen_pkg::*;
#(
  parameter int unsigned BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [15:0]       in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;

  logic [ACC_W-1:0]   ext;
  logic [ACC_W-1:0]   acc_plus;
  logic [CNT_W-1:0]   cnt_plus;
  logic               accept;
  logic               burst_done;

  int_widen u_widen (
    .kind (int_kind_e'(in_kind)),
    .d    (in_data),
    .ext  (ext)
  );

  // Handshake outputs come straight from the state register.
  assign in_ready   = (state_q == ST_ACC);
  assign out_valid  = (state_q == ST_EMIT);
  assign out_sum    = out_sum_q;
  assign out_count  = out_count_q;

  assign accept     = in_valid & in_ready;
  assign acc_plus   = acc_q + ext;
  assign cnt_plus   = cnt_q + 8'd1;
  assign burst_done = (cnt_q == CNT_W'(BURST - 1));

  // Next-state: accumulate, close a burst on count or flush, hold while emitting.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    unique case (state_q)
      ST_ACC: begin
        if (accept) begin
          // A flush coinciding with the burst-completing accept is the same emit.
          if (burst_done || flush) begin
            out_sum_d   = acc_plus;
            out_count_d = cnt_plus;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = ST_EMIT;
          end else begin
            acc_d = acc_plus;
            cnt_d = cnt_plus;
          end
        end else if (flush && (cnt_q != '0)) begin
          out_sum_d   = acc_q;
          out_count_d = cnt_q;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: tb/tb_int_widen_acc.sv
// Self-checking bench for int_widen_acc: transaction-level reference model
// plus directed literal checks, with a BURST=255 instance for long bursts.
module tb_int_widen_acc;

  localparam int unsigned B4 = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_kind = 2'd0;
  logic [15:0] in_data = 16'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_sum;
  logic [7:0]  out_count;

  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [1:0]  b_kind = 2'd0;
  logic [15:0] b_data = 16'd0;
  logic        b_flush = 1'b0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [31:0] b_out_sum;
  logic [7:0]  b_out_count;

  int total = 0;
  int bad   = 0;

  int_widen_acc #(.BURST(B4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count)
  );

  int_widen_acc #(.BURST(255)) dut255 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_kind(b_kind), .in_data(b_data), .flush(b_flush), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_sum(b_out_sum), .out_count(b_out_count)
  );

  always #5 clk = ~clk;

  // Reference widening from the integer types themselves.
  function automatic logic [31:0] widen_ref(input logic [1:0] k, input logic [15:0] d);
    byte     sb;
    shortint ss;
    case (k)
      2'd0:    begin sb = d[7:0]; return 32'(int'(sb)); end
      2'd1:    return 32'(d[7:0]);
      2'd2:    begin ss = d; return 32'(int'(ss)); end
      default: return 32'(d);
    endcase
  endfunction

  // Transaction-level model: collect widened samples, sum them on emit.
  bit          m_seen = 1'b0;
  bit          m_emit = 1'b0;
  logic [31:0] m_samples[$];
  logic [31:0] m_sum = '0;
  int          m_cnt = 0;

  initial forever begin
    logic [31:0] s;
    @(posedge clk);
    if (!rst_n) begin
      m_seen = 1'b1;
      m_emit = 1'b0;
      m_samples.delete();
      m_sum = '0;
      m_cnt = 0;
    end else if (!m_emit) begin
      if (in_valid) m_samples.push_back(widen_ref(in_kind, in_data));
      if (m_samples.size() == B4 || (flush && m_samples.size() > 0)) begin
        s = '0;
        foreach (m_samples[i]) s = s + m_samples[i];
        m_sum  = s;
        m_cnt  = m_samples.size();
        m_samples.delete();
        m_emit = 1'b1;
      end
    end else if (out_ready) begin
      m_emit = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (m_seen && rst_n) begin
      chk("model_in_ready", 32'(in_ready), 32'(!m_emit));
      chk("model_out_valid", 32'(out_valid), 32'(m_emit));
      if (m_emit && out_valid) begin
        chk("model_out_sum", out_sum, m_sum);
        chk("model_out_count", 32'(out_count), 32'(m_cnt));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic put(input logic [1:0] k, input logic [15:0] d, input logic fl);
    in_valid = 1'b1; in_kind = k; in_data = d; flush = fl;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    step(); step();
    rst_n = 1'b1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_sum", out_sum, 32'd0);
    chk("reset_out_count", 32'(out_count), 32'd0);

    // Extension of all four kinds.
    out_ready = 1'b1;
    put(2'd0, 16'h00FF, 1'b0);
    put(2'd1, 16'h00FE, 1'b0);
    put(2'd2, 16'hFFFD, 1'b0);
    put(2'd3, 16'hFFFC, 1'b0);
    chk("ext_valid", 32'(out_valid), 32'd1);
    chk("ext_sum", out_sum, 32'h000100F6);
    chk("ext_count", 32'(out_count), 32'd4);
    chk("ext_model_sum", m_sum, 32'h000100F6);
    step();
    chk("ext_valid_one_cycle", 32'(out_valid), 32'd0);

    // Byte kinds ignore the upper byte.
    for (int i = 0; i < 4; i++) put(2'd0, 16'hAB80, 1'b0);
    chk("mask_sum", out_sum, 32'hFFFFFE00);
    chk("mask_model_sum", m_sum, 32'hFFFFFE00);
    step();

    // Flush mid-burst, then a flush with nothing pending.
    put(2'd2, 16'h8000, 1'b0);
    put(2'd2, 16'h8000, 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd1);
    chk("flush_sum", out_sum, 32'hFFFF0000);
    chk("flush_count", 32'(out_count), 32'd2);
    step();
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_empty_no_valid", 32'(out_valid), 32'd0);

    // Flush with an accept on an empty burst emits that single sample.
    put(2'd1, 16'h0007, 1'b1);
    chk("flush_single_valid", 32'(out_valid), 32'd1);
    chk("flush_single_sum", out_sum, 32'd7);
    chk("flush_single_count", 32'(out_count), 32'd1);
    step();

    // Flush on the burst-completing accept emits exactly once.
    put(2'd1, 16'd1, 1'b0);
    put(2'd1, 16'd1, 1'b0);
    put(2'd1, 16'd1, 1'b0);
    put(2'd1, 16'd1, 1'b1);
    chk("flush_full_count", 32'(out_count), 32'd4);
    chk("flush_full_sum", out_sum, 32'd4);
    step();
    chk("flush_full_no_extra", 32'(out_valid), 32'd0);

    // Backpressure: hold the emit for 5 cycles with a sample waiting.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) put(2'd1, 16'(i), 1'b0);
    in_valid = 1'b1; in_kind = 2'd1; in_data = 16'h0055;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", out_sum, 32'd10);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);

    // Reset mid-burst discards the partial sum and clears outputs.
    for (int i = 0; i < 3; i++) put(2'd2, 16'h1234, 1'b0);
    do_reset();
    chk("rst_mid_out_sum", out_sum, 32'd0);
    chk("rst_mid_out_count", 32'(out_count), 32'd0);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) put(2'd1, 16'h0001, 1'b0);
    chk("rst_after_sum", out_sum, 32'h00000004);
    chk("rst_after_count", 32'(out_count), 32'd4);
    step();

    // Randomized traffic checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_kind   = 2'($urandom_range(0, 3));
      in_data   = 16'($urandom);
      flush     = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
    step(); step();

    // Long bursts on the BURST=255 instance.
    b_out_ready = 1'b1;
    b_valid = 1'b1; b_kind = 2'd3; b_data = 16'hFFFF;
    for (int i = 0; i < 255; i++) step();
    b_valid = 1'b0;
    chk("b255_valid", 32'(b_out_valid), 32'd1);
    chk("b255_sum", b_out_sum, 32'h00FEFF01);
    chk("b255_count", 32'(b_out_count), 32'd255);
    step();
    chk("b255_valid_drop", 32'(b_out_valid), 32'd0);
    b_valid = 1'b1; b_kind = 2'd2; b_data = 16'h8000;
    for (int i = 0; i < 255; i++) step();
    b_valid = 1'b0;
    chk("b255_neg_sum", b_out_sum, 32'hFF808000);
    chk("b255_neg_count", 32'(b_out_count), 32'd255);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
